// File: rtl/tx_token_scheduler_if.sv
// Token, FIFO, FCT and credit signals between the TX token scheduler and its
// neighbours (link FSM, TX FIFO, tx_fct_send, character encoder).
interface tx_token_scheduler_if #(
    parameter int unsigned CW = 6
);
    logic          send_null_only;
    logic          send_fct_en;
    logic          send_data_en;
    logic          tick_req;
    logic [7:0]    time_in;
    logic [2:0]    fct_pend;
    logic          fct_rx;
    logic          data_valid;
    logic [8:0]    data_in;
    logic          enc_ready;
    logic          tok_valid;
    logic [1:0]    tok_type;
    logic [8:0]    tok_data;
    logic          fct_sent;
    logic          data_rd;
    logic [CW-1:0] credit;
    logic          credit_err;

    modport master (
        input  send_null_only, send_fct_en, send_data_en, tick_req, time_in,
        input  fct_pend, fct_rx, data_valid, data_in, enc_ready,
        output tok_valid, tok_type, tok_data, fct_sent, data_rd, credit, credit_err
    );

    modport slave (
        output send_null_only, send_fct_en, send_data_en, tick_req, time_in,
        output fct_pend, fct_rx, data_valid, data_in, enc_ready,
        input  tok_valid, tok_type, tok_data, fct_sent, data_rd, credit, credit_err
    );
endinterface

// File: rtl/tx_token_scheduler.sv
// SpaceWire transmit token scheduler: picks time-code, FCT, N-char or NULL for
// the encoder and tracks the remote end's receive credit.
module tx_token_scheduler #(
    parameter int unsigned CREDIT_MAX  = 56,
    parameter int unsigned CREDIT_STEP = 8,
    parameter int unsigned CW          = 6
) (
    input  logic                 pclk_tx,
    input  logic                 rst_tx,
    tx_token_scheduler_if.master bus
);
    localparam int unsigned SW = CW + 1;

    localparam logic [1:0] TOK_NULL  = 2'b00;
    localparam logic [1:0] TOK_FCT   = 2'b01;
    localparam logic [1:0] TOK_NCHAR = 2'b10;
    localparam logic [1:0] TOK_TIME  = 2'b11;

    typedef enum logic {
        IDLE,
        HOLD
    } state_t;

    state_t        state;
    logic          tick_pend;
    logic [7:0]    tick_val;

    logic          active;
    logic          accept;
    logic          acc_fct;
    logic          acc_nchar;
    logic          acc_time;
    logic          elig_time;
    logic          elig_fct;
    logic          elig_nchar;
    logic [1:0]    next_type;
    logic [8:0]    next_data;
    logic [SW-1:0] credit_dec;
    logic [SW-1:0] credit_add;
    logic          credit_ovf;

    // Arbitration against the token being accepted on this same edge, so the
    // FCT and N-char guards also cover the cycle before fct_sent/data_rd rise.
    always_comb begin
        active     = bus.send_null_only | bus.send_fct_en | bus.send_data_en;
        accept     = (state == HOLD) & bus.enc_ready;
        acc_fct    = accept & (bus.tok_type == TOK_FCT);
        acc_nchar  = accept & (bus.tok_type == TOK_NCHAR);
        acc_time   = accept & (bus.tok_type == TOK_TIME);

        elig_time  = bus.send_data_en & tick_pend & ~acc_time;
        elig_fct   = (bus.send_fct_en | bus.send_data_en) & (bus.fct_pend != 3'd0)
                     & ~bus.fct_sent & ~acc_fct;
        elig_nchar = bus.send_data_en & bus.data_valid & (bus.credit != '0)
                     & ~bus.data_rd & ~acc_nchar;

        next_type  = TOK_NULL;
        next_data  = '0;
        if (elig_time) begin
            next_type = TOK_TIME;
            next_data = {1'b0, tick_val};
        end else if (elig_fct) begin
            next_type = TOK_FCT;
        end else if (elig_nchar) begin
            next_type = TOK_NCHAR;
            next_data = bus.data_in;
        end

        credit_dec = SW'(bus.credit) - SW'(acc_nchar);
        credit_add = credit_dec + SW'(CREDIT_STEP);
        credit_ovf = bus.fct_rx & (credit_add > SW'(CREDIT_MAX));
    end

    always_ff @(posedge pclk_tx or posedge rst_tx) begin
        if (rst_tx) begin
            state          <= IDLE;
            tick_pend      <= 1'b0;
            tick_val       <= '0;
            bus.tok_valid  <= 1'b0;
            bus.tok_type   <= TOK_NULL;
            bus.tok_data   <= '0;
            bus.fct_sent   <= 1'b0;
            bus.data_rd    <= 1'b0;
            bus.credit     <= '0;
            bus.credit_err <= 1'b0;
        end else begin
            bus.fct_sent <= acc_fct;
            bus.data_rd  <= acc_nchar;

            // A new request always wins over the clear from a time-code acceptance.
            if (bus.tick_req) begin
                tick_pend <= 1'b1;
                tick_val  <= bus.time_in;
            end else if (acc_time) begin
                tick_pend <= 1'b0;
            end

            if (credit_ovf) begin
                bus.credit_err <= 1'b1;
            end
            if (bus.fct_rx && !credit_ovf) begin
                bus.credit <= CW'(credit_add);
            end else begin
                bus.credit <= CW'(credit_dec);
            end

            case (state)
                IDLE: begin
                    if (active) begin
                        state         <= HOLD;
                        bus.tok_valid <= 1'b1;
                        bus.tok_type  <= next_type;
                        bus.tok_data  <= next_data;
                    end
                end
                HOLD: begin
                    if (accept && active) begin
                        bus.tok_type <= next_type;
                        bus.tok_data <= next_data;
                    end else if (accept) begin
                        state         <= IDLE;
                        bus.tok_valid <= 1'b0;
                        bus.tok_type  <= TOK_NULL;
                        bus.tok_data  <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_tx_token_scheduler.sv
// Bench for tx_token_scheduler: directed vector table, hand-written corner
// sequences and randomized traffic against a behavioural token model.
module tb_tx_token_scheduler;
    localparam int unsigned CW = 6;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    tx_token_scheduler_if #(.CW(CW)) bus ();

    tx_token_scheduler #(
        .CREDIT_MAX (56),
        .CREDIT_STEP(8),
        .CW         (CW)
    ) dut (
        .pclk_tx(clk),
        .rst_tx (rst),
        .bus    (bus)
    );

    typedef struct {
        int nul, fct, dat, er, frx, tick, tin, dv, din, pend;
        int ev, et, ed, efs, edr, ec, ee;
    } vec_t;

    localparam int NV = 21;
    vec_t vecs[NV];

    int checks = 0;
    int passes = 0;

    // Environment: show-ahead FIFO, expected N-char order, FCTs owed
    logic [8:0] fifo[$];
    logic [8:0] order[$];
    int fct_pend_v;

    // Behavioural model state
    bit m_valid, m_err, m_tpend, m_fs, m_dr;
    int m_type, m_data, m_credit, m_tval;

    int acc_cnt[4];
    int fs_cnt, dr_cnt, b2b, prev_acc;

    task automatic check(string name, int act, int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    function automatic int dut_pack();
        return int'({bus.tok_valid, bus.tok_type, bus.tok_data, bus.fct_sent,
                     bus.data_rd, bus.credit, bus.credit_err});
    endfunction

    function automatic int model_pack();
        return int'({1'(m_valid), 2'(m_type), 9'(m_data), 1'(m_fs), 1'(m_dr),
                     6'(m_credit), 1'(m_err)});
    endfunction

    function automatic int vec_pack(vec_t v);
        return int'({1'(v.ev), 2'(v.et), 9'(v.ed), 1'(v.efs), 1'(v.edr),
                     6'(v.ec), 1'(v.ee)});
    endfunction

    task automatic model_reset();
        m_valid = 0; m_err = 0; m_tpend = 0; m_fs = 0; m_dr = 0;
        m_type = 0; m_data = 0; m_credit = 0; m_tval = 0;
    endtask

    // One clock edge of the scheduler, from the token rules with plain integers
    task automatic model_edge();
        bit active, acc, dec;
        int ot, nc, typ;
        active = bus.send_null_only | bus.send_fct_en | bus.send_data_en;
        ot  = m_type;
        acc = m_valid && bus.enc_ready;
        dec = acc && ot == 2;
        nc  = m_credit - (dec ? 1 : 0);
        if (bus.fct_rx) begin
            if (nc + 8 > 56) m_err = 1;
            else nc = nc + 8;
        end
        if (!m_valid || acc) begin
            if (active) begin
                typ = 0;
                if (bus.send_data_en && m_tpend && !(acc && ot == 3)) typ = 3;
                else if ((bus.send_fct_en || bus.send_data_en) && bus.fct_pend != 3'd0
                         && !m_fs && !(acc && ot == 1)) typ = 1;
                else if (bus.send_data_en && bus.data_valid && m_credit != 0
                         && !m_dr && !dec) typ = 2;
                m_data  = (typ == 3) ? m_tval : (typ == 2) ? int'(bus.data_in) : 0;
                m_type  = typ;
                m_valid = 1;
            end else begin
                m_valid = 0; m_type = 0; m_data = 0;
            end
        end
        if (bus.tick_req) begin
            m_tpend = 1;
            m_tval  = int'(bus.time_in);
        end else if (acc && ot == 3) begin
            m_tpend = 0;
        end
        m_fs = acc && ot == 1;
        m_dr = dec;
        m_credit = nc;
    endtask

    task automatic refresh_env();
        bus.data_valid = (fifo.size() != 0);
        bus.data_in    = (fifo.size() != 0) ? fifo[0] : 9'h000;
        bus.fct_pend   = 3'(fct_pend_v);
    endtask

    task automatic push_char(logic [8:0] c);
        fifo.push_back(c);
        order.push_back(c);
    endtask

    task automatic clear_counts();
        for (int i = 0; i < 4; i++) acc_cnt[i] = 0;
        fs_cnt = 0; dr_cnt = 0; b2b = 0; prev_acc = -1;
    endtask

    // One clock with environment, scoreboard and model comparison
    task automatic step();
        bit pre_rd, pre_fs;
        int t;
        pre_rd = bus.data_rd;
        pre_fs = bus.fct_sent;
        if (bus.tok_valid && bus.enc_ready) begin
            t = int'(bus.tok_type);
            acc_cnt[t]++;
            if (t == 1 && prev_acc == 1) b2b++;
            prev_acc = t;
            if (t == 2) begin
                if (order.size() == 0) check("nchar_order", int'(bus.tok_data), -1);
                else check("nchar_order", int'(bus.tok_data), int'(order.pop_front()));
            end
        end
        model_edge();
        @(posedge clk);
        #1;
        if (pre_rd && fifo.size() != 0) void'(fifo.pop_front());
        if (pre_fs && fct_pend_v > 0) fct_pend_v--;
        bus.tick_req = 1'b0;
        bus.fct_rx   = 1'b0;
        refresh_env();
        check("cycle", dut_pack(), model_pack());
        fs_cnt += int'(bus.fct_sent);
        dr_cnt += int'(bus.data_rd);
    endtask

    task automatic clear_inputs();
        bus.send_null_only = 1'b0; bus.send_fct_en = 1'b0; bus.send_data_en = 1'b0;
        bus.tick_req = 1'b0; bus.time_in = 8'h00; bus.fct_rx = 1'b0;
        bus.enc_ready = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        fifo.delete();
        order.delete();
        fct_pend_v = 0;
        model_reset();
        refresh_env();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic fill_vecs();
        //          nul fct dat er frx tk tin   dv din    pd   ev et ed     fs dr cr ee
        vecs[0]  = '{0, 0, 0, 0, 0, 0, 0,    0, 0,     0,   0, 0, 0,     0, 0, 0,  0};
        vecs[1]  = '{1, 0, 0, 1, 0, 0, 0,    0, 0,     0,   1, 0, 0,     0, 0, 0,  0};
        vecs[2]  = '{1, 0, 0, 1, 1, 0, 0,    0, 0,     0,   1, 0, 0,     0, 0, 8,  0};
        vecs[3]  = '{0, 1, 0, 1, 0, 0, 0,    0, 0,     1,   1, 1, 0,     0, 0, 8,  0};
        vecs[4]  = '{0, 1, 0, 0, 0, 0, 0,    0, 0,     1,   1, 1, 0,     0, 0, 8,  0};
        vecs[5]  = '{0, 1, 0, 1, 0, 0, 0,    0, 0,     1,   1, 0, 0,     1, 0, 8,  0};
        vecs[6]  = '{0, 1, 0, 1, 0, 0, 0,    0, 0,     1,   1, 0, 0,     0, 0, 8,  0};
        vecs[7]  = '{0, 0, 1, 1, 0, 0, 0,    1, 'h141, 0,   1, 2, 'h141, 0, 0, 8,  0};
        vecs[8]  = '{0, 0, 1, 1, 0, 1, 'h2A, 1, 'h141, 0,   1, 0, 0,     0, 1, 7,  0};
        vecs[9]  = '{0, 0, 1, 0, 0, 1, 'h15, 1, 'h0FF, 0,   1, 0, 0,     0, 0, 7,  0};
        vecs[10] = '{0, 0, 1, 1, 0, 0, 0,    1, 'h0FF, 0,   1, 3, 'h015, 0, 0, 7,  0};
        vecs[11] = '{0, 0, 1, 1, 0, 1, 'h33, 1, 'h0FF, 0,   1, 2, 'h0FF, 0, 0, 7,  0};
        vecs[12] = '{0, 0, 1, 1, 1, 0, 0,    1, 'h0FF, 0,   1, 3, 'h033, 0, 1, 14, 0};
        vecs[13] = '{0, 0, 1, 1, 0, 0, 0,    1, 'h100, 0,   1, 0, 0,     0, 0, 14, 0};
        vecs[14] = '{0, 0, 1, 1, 0, 0, 0,    1, 'h100, 0,   1, 2, 'h100, 0, 0, 14, 0};
        vecs[15] = '{0, 0, 0, 1, 0, 0, 0,    1, 'h100, 0,   0, 0, 0,     0, 1, 13, 0};
        vecs[16] = '{0, 0, 0, 0, 0, 0, 0,    0, 0,     0,   0, 0, 0,     0, 0, 13, 0};
        vecs[17] = '{1, 1, 1, 0, 0, 0, 0,    1, 'h055, 0,   1, 2, 'h055, 0, 0, 13, 0};
        vecs[18] = '{1, 1, 0, 1, 0, 0, 0,    1, 'h055, 2,   1, 1, 0,     0, 1, 12, 0};
        vecs[19] = '{0, 0, 0, 0, 0, 0, 0,    0, 0,     2,   1, 1, 0,     0, 0, 12, 0};
        vecs[20] = '{0, 0, 0, 1, 0, 0, 0,    0, 0,     2,   0, 0, 0,     1, 0, 12, 0};
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [11:0] snap;
        logic [2:0]  mode;
        bit          hit;

        fill_vecs();
        do_reset();
        check("reset_state", dut_pack(), 0);

        // Directed vector table, inputs driven straight onto the bus
        for (int i = 0; i < NV; i++) begin
            bus.send_null_only = 1'(vecs[i].nul);
            bus.send_fct_en    = 1'(vecs[i].fct);
            bus.send_data_en   = 1'(vecs[i].dat);
            bus.enc_ready      = 1'(vecs[i].er);
            bus.fct_rx         = 1'(vecs[i].frx);
            bus.tick_req       = 1'(vecs[i].tick);
            bus.time_in        = 8'(vecs[i].tin);
            bus.data_valid     = 1'(vecs[i].dv);
            bus.data_in        = 9'(vecs[i].din);
            bus.fct_pend       = 3'(vecs[i].pend);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", i), dut_pack(), vec_pack(vecs[i]));
        end

        // Null-only link: continuous NULLs, no pulses, no credit
        do_reset();
        clear_counts();
        bus.send_null_only = 1'b1;
        bus.enc_ready = 1'b1;
        step();
        check("null_valid_rise", int'(bus.tok_valid), 1);
        repeat (10) step();
        check("null_only_types", acc_cnt[0], 10);
        check("null_no_pulses", fs_cnt + dr_cnt, 0);

        // Seven owed FCTs, each followed by at least one NULL
        do_reset();
        clear_counts();
        fct_pend_v = 7;
        refresh_env();
        bus.send_fct_en = 1'b1;
        bus.enc_ready = 1'b1;
        repeat (40) step();
        check("fct_tokens", acc_cnt[1], 7);
        check("fct_sent_pulses", fs_cnt, 7);
        check("fct_back_to_back", b2b, 0);
        check("fct_then_null", int'(bus.tok_type), 0);

        // Credit 16 with 20 queued characters
        do_reset();
        clear_counts();
        for (int i = 0; i < 20; i++) push_char(9'(i * 23 + 3));
        refresh_env();
        bus.send_data_en = 1'b1;
        bus.enc_ready = 1'b1;
        bus.fct_rx = 1'b1;
        step();
        bus.fct_rx = 1'b1;
        step();
        repeat (80) step();
        check("nchar_count", acc_cnt[2], 16);
        check("data_rd_pulses", dr_cnt, 16);
        check("credit_drained", int'(bus.credit), 0);
        check("fifo_left", fifo.size(), 4);
        check("null_after_drain", int'(bus.tok_type), 0);

        // Credit overflow at the upper bound
        do_reset();
        bus.send_null_only = 1'b1;
        bus.enc_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            bus.fct_rx = 1'b1;
            step();
        end
        check("credit_full", int'(bus.credit), 56);
        check("credit_err_clear", int'(bus.credit_err), 0);
        bus.fct_rx = 1'b1;
        step();
        check("credit_err_set", int'(bus.credit_err), 1);
        check("credit_capped", int'(bus.credit), 56);
        repeat (3) step();
        check("credit_err_sticky", int'(bus.credit_err), 1);

        // fct_rx on the same edge as an N-char acceptance at credit 10
        do_reset();
        for (int i = 0; i < 10; i++) push_char(9'(i + 'h20));
        refresh_env();
        bus.send_data_en = 1'b1;
        bus.enc_ready = 1'b1;
        bus.fct_rx = 1'b1;
        step();
        bus.fct_rx = 1'b1;
        step();
        hit = 0;
        for (int i = 0; i < 200 && !hit; i++) begin
            if (bus.tok_valid && bus.tok_type == 2'b10 && bus.credit == 6'd10) begin
                bus.fct_rx = 1'b1;
                hit = 1;
                step();
                check("credit_add_sub", int'(bus.credit), 17);
            end else begin
                step();
            end
        end
        check("credit10_reached", int'(hit), 1);

        // Held token stable under back-pressure, then asynchronous reset mid-hold
        do_reset();
        clear_counts();
        fct_pend_v = 1;
        refresh_env();
        bus.send_fct_en = 1'b1;
        bus.enc_ready = 1'b0;
        step();
        check("hold_type", int'(bus.tok_type), 1);
        snap = {bus.tok_valid, bus.tok_type, bus.tok_data};
        for (int i = 0; i < 5; i++) begin
            step();
            check("hold_stable", int'({bus.tok_valid, bus.tok_type, bus.tok_data}), int'(snap));
        end
        bus.enc_ready = 1'b1;
        #3 rst = 1'b1;
        #1;
        check("async_reset", dut_pack(), 0);
        do_reset();
        clear_counts();
        repeat (3) step();
        check("no_pulse_after_reset", fs_cnt + dr_cnt, 0);

        // Randomized traffic against the model
        do_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc % 750 == 749) do_reset();
            if ($urandom_range(0, 39) == 0) begin
                mode = 3'($urandom);
                bus.send_null_only = mode[0];
                bus.send_fct_en    = mode[1];
                bus.send_data_en   = mode[2] | mode[0];
            end
            bus.enc_ready = ($urandom_range(0, 9) < 7);
            bus.tick_req  = ($urandom_range(0, 24) == 0);
            bus.time_in   = 8'($urandom);
            bus.fct_rx    = ($urandom_range(0, 19) == 0);
            if (fifo.size() < 16 && $urandom_range(0, 2) == 0) push_char(9'($urandom));
            if (fct_pend_v < 7 && $urandom_range(0, 19) == 0) fct_pend_v++;
            refresh_env();
            step();
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
